// File: rtl/trdb_filter_multi.sv
`default_nettype none
// ============================================================================
// Module      : trdb_filter_multi
// Description : Trace qualification filter with multiple address-range
//               comparators, start/stop triggers and a qualified-count stop.
// Revision    : 1.0 - initial release
// ============================================================================
module trdb_filter_multi #(
  parameter int XLEN    = 32,
  parameter int NRANGES = 4,
  parameter int CNTW    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    trace_activated_i,
  input  logic                    apply_filters_i,
  input  logic                    ivalid_i,
  input  logic [XLEN-1:0]         iaddr_i,
  input  logic [NRANGES-1:0]      range_en_i,
  input  logic [2*NRANGES-1:0]    range_mode_i,
  input  logic [NRANGES*XLEN-1:0] range_lo_i,
  input  logic [NRANGES*XLEN-1:0] range_hi_i,
  input  logic [CNTW-1:0]         stop_count_i,
  output logic                    trace_qualified_o,
  output logic                    trace_req_deactivate_o,
  output logic [NRANGES-1:0]      range_match_o,
  output logic [1:0]              state_o,
  output logic [CNTW-1:0]         qual_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_WAIT_START = 2'b01,
    ST_TRACING    = 2'b10,
    ST_STOPPED    = 2'b11
  } state_t;

  localparam logic [1:0] c_mode_qual  = 2'b00;
  localparam logic [1:0] c_mode_start = 2'b01;
  localparam logic [1:0] c_mode_stop  = 2'b10;

  state_t            r_state;
  state_t            w_next;
  logic              w_qual;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_inc;
  logic [NRANGES-1:0] w_hit;
  logic [NRANGES-1:0] w_qual_en;
  logic [NRANGES-1:0] w_qual_hit;
  logic [NRANGES-1:0] w_start_en;
  logic [NRANGES-1:0] w_start_hit;
  logic [NRANGES-1:0] w_stop_hit;
  logic              w_qual_ok;
  logic              w_has_start;
  logic              w_any_start;
  logic              w_any_stop;

  // Per-range comparators; an empty or inverted range never hits.
  generate
    for (genvar k = 0; k < NRANGES; k++) begin : g_range
      logic [XLEN-1:0] w_lo;
      logic [XLEN-1:0] w_hi;
      logic [1:0]      w_mode;
      assign w_lo           = range_lo_i[k*XLEN +: XLEN];
      assign w_hi           = range_hi_i[k*XLEN +: XLEN];
      assign w_mode         = range_mode_i[2*k +: 2];
      assign w_hit[k]       = range_en_i[k] && (w_lo < w_hi) &&
                              (iaddr_i >= w_lo) && (iaddr_i < w_hi);
      assign w_qual_en[k]   = range_en_i[k] && (w_mode == c_mode_qual);
      assign w_qual_hit[k]  = w_hit[k] && (w_mode == c_mode_qual);
      assign w_start_en[k]  = range_en_i[k] && (w_mode == c_mode_start);
      assign w_start_hit[k] = w_hit[k] && (w_mode == c_mode_start);
      assign w_stop_hit[k]  = w_hit[k] && (w_mode == c_mode_stop);
    end
  endgenerate

  assign w_qual_ok   = (~|w_qual_en) || (|w_qual_hit);
  assign w_has_start = |w_start_en;
  assign w_any_start = |w_start_hit;
  assign w_any_stop  = |w_stop_hit;
  assign w_cnt_inc   = (r_cnt == {CNTW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    w_qual = 1'b0;
    if (!trace_activated_i) begin
      w_next = ST_IDLE;
    end else if (!apply_filters_i) begin
      w_next = ST_IDLE;
      w_qual = ivalid_i;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next = w_has_start ? ST_WAIT_START : ST_TRACING;
        end
        ST_WAIT_START: begin
          if (ivalid_i && w_any_start && !w_any_stop) begin
            w_next = ST_TRACING;
            w_qual = w_qual_ok;
          end
        end
        ST_TRACING: begin
          if (ivalid_i && w_any_stop) begin
            w_next = ST_STOPPED;
          end else if (ivalid_i && w_qual_ok) begin
            w_qual = 1'b1;
          end
        end
        default: w_next = ST_STOPPED;
      endcase
      // The instruction that reaches the limit is still traced.
      if (w_qual && (stop_count_i != '0) && (w_cnt_inc == stop_count_i)) begin
        w_next = ST_STOPPED;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state                <= ST_IDLE;
      r_cnt                  <= '0;
      trace_qualified_o      <= 1'b0;
      trace_req_deactivate_o <= 1'b0;
      range_match_o          <= '0;
    end else begin
      r_state                <= w_next;
      trace_qualified_o      <= w_qual;
      trace_req_deactivate_o <= (w_next == ST_STOPPED) && (r_state != ST_STOPPED);
      range_match_o          <= w_hit;
      if (!trace_activated_i || ((r_state != ST_IDLE) && (w_next == ST_IDLE))) begin
        r_cnt <= '0;
      end else if (w_qual) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign state_o    = r_state;
  assign qual_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trdb_filter_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_trdb_filter_multi
// Description : Self-checking bench: directed vector tables plus randomized
//               traffic against a flag-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_filter_multi;

  localparam int XLEN = 32;
  localparam int NR   = 4;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              act, apply, ivalid;
  logic [XLEN-1:0]   iaddr;
  logic [NR-1:0]     en;
  logic [2*NR-1:0]   mode;
  logic [NR*XLEN-1:0] lo, hi;
  logic [CNTW-1:0]   stop_count;
  logic              q_o, deact_o;
  logic [NR-1:0]     match_o;
  logic [1:0]        state_o;
  logic [CNTW-1:0]   cnt_o;

  int n_pass = 0;
  int n_tot  = 0;

  trdb_filter_multi #(.XLEN(XLEN), .NRANGES(NR), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_i(rst), .trace_activated_i(act), .apply_filters_i(apply),
    .ivalid_i(ivalid), .iaddr_i(iaddr), .range_en_i(en), .range_mode_i(mode),
    .range_lo_i(lo), .range_hi_i(hi), .stop_count_i(stop_count),
    .trace_qualified_o(q_o), .trace_req_deactivate_o(deact_o),
    .range_match_o(match_o), .state_o(state_o), .qual_cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase flags and an integer count.
  logic m_wait, m_trace, m_stop, m_q, m_deact;
  logic [NR-1:0] m_match;
  int m_cnt;

  task automatic model_reset();
    m_wait = 0; m_trace = 0; m_stop = 0; m_q = 0; m_deact = 0; m_match = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [NR-1:0] h;
    logic qa, qh, sh, ph, hs, q, was_stop;
    logic [31:0] l, u;
    logic [1:0] md;
    qa = 0; qh = 0; sh = 0; ph = 0; hs = 0; q = 0;
    for (int k = 0; k < NR; k++) begin
      l = lo[32*k +: 32]; u = hi[32*k +: 32]; md = mode[2*k +: 2];
      h[k] = en[k] && (l < u) && (iaddr >= l) && (iaddr < u);
      if (en[k] && md == 2'd0) qa = 1;
      if (h[k]  && md == 2'd0) qh = 1;
      if (h[k]  && md == 2'd1) sh = 1;
      if (h[k]  && md == 2'd2) ph = 1;
      if (en[k] && md == 2'd1) hs = 1;
    end
    was_stop = m_stop;
    if (!act) begin
      m_wait = 0; m_trace = 0; m_stop = 0; m_cnt = 0;
    end else if (!apply) begin
      q = ivalid;
      if (m_wait || m_trace || m_stop) begin
        m_wait = 0; m_trace = 0; m_stop = 0; m_cnt = 0;
      end else if (ivalid) begin
        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
    end else begin
      if (!(m_wait || m_trace || m_stop)) begin
        if (hs) m_wait = 1; else m_trace = 1;
      end else if (m_wait) begin
        if (ivalid && sh && !ph) begin m_wait = 0; m_trace = 1; q = !qa || qh; end
      end else if (m_trace) begin
        if (ivalid && ph) begin m_trace = 0; m_stop = 1; end
        else if (ivalid && (!qa || qh)) q = 1;
      end
      if (q) begin
        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        if (stop_count != 0 && m_cnt == int'(stop_count)) begin
          m_wait = 0; m_trace = 0; m_stop = 1;
        end
      end
    end
    m_q = q;
    m_deact = m_stop && !was_stop;
    m_match = h;
  endtask

  function automatic logic [1:0] m_state();
    return m_stop ? 2'd3 : m_trace ? 2'd2 : m_wait ? 2'd1 : 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_range(input int k, input logic e, input logic [1:0] md,
                           input logic [31:0] l, input logic [31:0] h);
    en[k] = e; mode[2*k +: 2] = md; lo[32*k +: 32] = l; hi[32*k +: 32] = h;
  endtask

  task automatic clear_ranges();
    en = '0; mode = '1; lo = '0; hi = '0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        q;
    logic [3:0]  m;
    logic [1:0]  st;
    logic        d;
  } vec_t;
  vec_t tbl[8];

  task automatic run_table(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      ivalid = 1; iaddr = tbl[i].addr;
      tick();
      chk({tag, "_qual"},  32'(q_o),     32'(tbl[i].q));
      chk({tag, "_match"}, 32'(match_o), 32'(tbl[i].m));
      chk({tag, "_state"}, 32'(state_o), 32'(tbl[i].st));
      chk({tag, "_deact"}, 32'(deact_o), 32'(tbl[i].d));
    end
    ivalid = 0;
  endtask

  int ndeact;

  initial begin
    tbl[0] = '{32'h0FFC, 1'b0, 4'h0, 2'd2, 1'b0};
    tbl[1] = '{32'h1000, 1'b1, 4'h1, 2'd2, 1'b0};
    tbl[2] = '{32'h1FFC, 1'b1, 4'h1, 2'd2, 1'b0};
    tbl[3] = '{32'h2000, 1'b0, 4'h0, 2'd2, 1'b0};
    tbl[4] = '{32'h0080, 1'b0, 4'h0, 2'd1, 1'b0};
    tbl[5] = '{32'h0100, 1'b1, 4'h1, 2'd2, 1'b0};
    tbl[6] = '{32'h0150, 1'b1, 4'h0, 2'd2, 1'b0};
    tbl[7] = '{32'h0200, 1'b0, 4'h2, 2'd3, 1'b1};

    rst = 1; act = 0; apply = 0; ivalid = 0; iaddr = '0; stop_count = '0;
    clear_ranges();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_qual", 32'(q_o), 0);
    chk("rst_deact", 32'(deact_o), 0);
    chk("rst_match", 32'(match_o), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_cnt", 32'(cnt_o), 0);
    rst = 0;

    // Bypass: five instructions, then saturation of the narrow counter.
    act = 1; apply = 0;
    for (int i = 0; i < 5; i++) begin
      ivalid = 1; iaddr = 32'(i * 4);
      tick();
      chk("byp_qual", 32'(q_o), 1);
    end
    ivalid = 0;
    tick();
    chk("byp_idle_qual", 32'(q_o), 0);
    chk("byp_cnt", 32'(cnt_o), 5);
    chk("byp_state", 32'(state_o), 0);
    ivalid = 1;
    repeat (12) tick();
    ivalid = 0;
    tick();
    chk("byp_sat", 32'(cnt_o), CMAX);
    act = 0;
    tick();
    chk("deact_clr_cnt", 32'(cnt_o), 0);

    // Qualify range [0x1000,0x2000).
    set_range(0, 1, 2'b00, 32'h1000, 32'h2000);
    act = 1; apply = 1;
    tick();
    chk("qr_enter", 32'(state_o), 2);
    run_table(0, 3, "qr");
    tick();
    chk("qr_cnt", 32'(cnt_o), 2);

    // Start/stop ranges.
    act = 0; tick();
    clear_ranges();
    set_range(0, 1, 2'b01, 32'h100, 32'h104);
    set_range(1, 1, 2'b10, 32'h200, 32'h204);
    act = 1;
    tick();
    chk("ss_wait", 32'(state_o), 1);
    run_table(4, 7, "ss");
    tick();
    chk("ss_pulse_end", 32'(deact_o), 0);
    chk("ss_hold", 32'(state_o), 3);

    // Count stop at 3.
    act = 0; tick();
    clear_ranges();
    stop_count = 3;
    act = 1; tick();
    ndeact = 0;
    for (int i = 0; i < 4; i++) begin
      ivalid = 1; iaddr = 32'h40 + 32'(i);
      tick();
      ndeact += int'(deact_o);
      chk("cs_qual", 32'(q_o), (i < 3) ? 1 : 0);
      if (i == 2) chk("cs_state", 32'(state_o), 3);
    end
    ivalid = 0; tick();
    ndeact += int'(deact_o);
    chk("cs_pulses", 32'(ndeact), 1);
    chk("cs_cnt", 32'(cnt_o), 3);
    stop_count = 0;

    // Conflicting start/stop, then asynchronous reset while tracing.
    act = 0; tick();
    clear_ranges();
    set_range(0, 1, 2'b01, 32'h300, 32'h304);
    set_range(1, 1, 2'b10, 32'h300, 32'h304);
    act = 1; tick();
    ivalid = 1; iaddr = 32'h300;
    tick();
    chk("cf_state", 32'(state_o), 1);
    chk("cf_qual", 32'(q_o), 0);
    en[1] = 0;
    tick();
    chk("cf_start", 32'(state_o), 2);
    chk("cf_start_q", 32'(q_o), 1);
    iaddr = 32'h10;
    tick();
    chk("cf_trace_q", 32'(q_o), 1);
    #2 rst = 1;
    #1;
    chk("ar_qual", 32'(q_o), 0);
    chk("ar_state", 32'(state_o), 0);
    chk("ar_cnt", 32'(cnt_o), 0);
    chk("ar_match", 32'(match_o), 0);
    chk("ar_deact", 32'(deact_o), 0);
    @(posedge clk); #1;
    rst = 0; ivalid = 0;
    model_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 25 == 0) begin
        for (int k = 0; k < NR; k++)
          set_range(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    32'($urandom_range(0, 63)), 32'($urandom_range(0, 63)));
        stop_count = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 6)) : 4'd0;
      end
      act    = ($urandom_range(0, 19) != 0);
      apply  = ($urandom_range(0, 9) != 0);
      ivalid = 1'($urandom_range(0, 1));
      iaddr  = 32'($urandom_range(0, 63));
      tick();
      chk("rnd_qual",  32'(q_o),     32'(m_q));
      chk("rnd_deact", 32'(deact_o), 32'(m_deact));
      chk("rnd_match", 32'(match_o), 32'(m_match));
      chk("rnd_state", 32'(state_o), 32'(m_state()));
      chk("rnd_cnt",   32'(cnt_o),   32'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trdb_filter_multi.md
TRDB_FILTER_MULTI -- requirements
Module: trdb_filter_multi

Interface
REQ-001 Parameter XLEN, default 32, address width.
REQ-002 Parameter NRANGES, default 4, number of address-range comparators (1..16).
REQ-003 Parameter CNTW, default 16, width of the qualified-instruction counter.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 trace_activated_i  input  1  user trace enable.
REQ-007 apply_filters_i  input  1  0 = bypass all filtering.
REQ-008 ivalid_i  input  1  an instruction retires this cycle.
REQ-009 iaddr_i  input  XLEN  address of the retiring instruction.
REQ-010 range_en_i  input  NRANGES  per-range enable.
REQ-011 range_mode_i  input  2*NRANGES  per-range mode: 00 qualify, 01 start, 10 stop, 11 disabled.
REQ-012 range_lo_i, range_hi_i  input  NRANGES*XLEN each  range bounds, inclusive low, exclusive high.
REQ-013 stop_count_i  input  CNTW  stop after this many qualified instructions; 0 = unlimited.
REQ-014 trace_qualified_o  output  1  registered; the instruction from the previous cycle is to be traced.
REQ-015 trace_req_deactivate_o  output  1  one-cycle pulse on entry to STOPPED.
REQ-016 range_match_o  output  NRANGES  registered per-range hit (range_en_i AND in range, all modes), valid with trace_qualified_o.
REQ-017 state_o  output  2  FSM state: 00 IDLE, 01 WAIT_START, 10 TRACING, 11 STOPPED.
REQ-018 qual_cnt_o  output  CNTW  qualified-instruction count.

Function
REQ-019 Hit k: range_en_i[k] AND lo_k <= iaddr_i < hi_k, unsigned; a range with lo_k >= hi_k never hits.
REQ-020 qual_ok: 1 if no enabled range has mode 00, otherwise the OR of the mode-00 hits. start_hit/stop_hit: OR of the mode-01/mode-10 hits. has_start: at least one enabled range has mode 01.
REQ-021 Bypass (apply_filters_i=0): trace_qualified_o <= ivalid_i AND trace_activated_i; FSM held in IDLE; the counter still counts; stop_count_i is ignored.
REQ-022 IDLE -> TRACING when trace_activated_i AND apply_filters_i AND !has_start; IDLE -> WAIT_START when has_start.
REQ-023 WAIT_START: ivalid_i AND start_hit AND !stop_hit -> TRACING; that instruction is qualified if qual_ok.
REQ-024 TRACING: each ivalid_i with qual_ok is qualified. ivalid_i AND stop_hit -> STOPPED; the stop instruction is not qualified.
REQ-025 Simultaneous start_hit and stop_hit in any state: stop wins (WAIT_START stays, TRACING stops, no qualification).
REQ-026 Count stop: when stop_count_i != 0 and a qualified instruction makes qual_cnt reach stop_count_i, that instruction is qualified and the next state is STOPPED.
REQ-027 STOPPED: no qualification; stays until trace_activated_i=0.
REQ-028 From any state, trace_activated_i=0 -> IDLE next cycle, with no qualification that cycle; qual_cnt clears on entry to IDLE.
REQ-029 qual_cnt increments by 1 per qualified instruction and saturates at 2^CNTW-1.
REQ-030 Latency: exactly 1 cycle from ivalid_i to trace_qualified_o and range_match_o; ivalid_i=0 gives trace_qualified_o=0 next cycle.
REQ-031 Range-configuration inputs are sampled every cycle; changes take effect on the next ivalid_i.

Reset
REQ-032 While rst_i=1: state IDLE, trace_qualified_o=0, trace_req_deactivate_o=0, range_match_o=0, qual_cnt_o=0; this holds mid-operation, asynchronously.
REQ-033 First evaluation after release uses the inputs in the first clock edge with rst_i=0.

Verification
REQ-034 Bypass: apply=0, activated=1, ivalid on 5 cycles -> 5 qualified pulses one cycle later, qual_cnt_o=5, state_o=00.
REQ-035 Qualify range: range0 mode 00 [0x1000,0x2000), iaddr 0x0FFC, 0x1000, 0x1FFC, 0x2000 -> qualified 0,1,1,0; range_match_o[0] 0,1,1,0.
REQ-036 Start/stop: range0 start [0x100,0x104), range1 stop [0x200,0x204), iaddr 0x80, 0x100, 0x150, 0x200 -> qualified 0,1,1,0; deactivate pulse after 0x200; state_o 01->10->11.
REQ-037 Count stop: no start ranges, stop_count=3, 4 consecutive ivalid -> 3 qualified, STOPPED after the 3rd, one deactivate pulse, qual_cnt_o=3.
REQ-038 Conflict and reset: a start range and a stop range both covering 0x300, iaddr=0x300 in WAIT_START -> stays 01, not qualified; then assert rst_i mid-TRACING -> all outputs 0 immediately, state_o=00.
